pe_loop_sequencer: RTL
======================

PE_LOOP_SEQUENCER -- requirements
Module: pe_loop_sequencer

Interface
REQ-001 Parameter NDEPTH, default 4: number of nested loop levels; level 0 is innermost.
REQ-002 Parameter IDXW, default 8: width of each loop index and loop size.
REQ-003 Parameter AW, default 8: width of every pad address and stride.
REQ-004 Parameter NRED, default 2: levels 0..NRED-1 are reduction levels that accumulate into one psum; range 1..NDEPTH.
REQ-005 Port i_clk, input, 1: the single clock.
REQ-006 Port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 i_start  input  1  launches a loop nest from IDLE.
REQ-008 i_clear  input  1  synchronous abort to IDLE, active-high.
REQ-009 i_stall  input  1  freezes iteration.
REQ-010 i_size  input  NDEPTH x IDXW  iteration count per level; 0 is illegal.
REQ-011 i_istride, i_wstride, i_pstride  input  NDEPTH x AW each  per-level address strides for the input, weight and psum pads.
REQ-012 Input_rdy  input  1 / Input_ack  output  1  input-operand handshake.
REQ-013 Weight_rdy  input  1 / Weight_ack  output  1  weight-operand handshake.
REQ-014 o_valid  output  1  the iteration addresses are valid.
REQ-015 o_iaddr, o_waddr, o_paddr  output  AW each  pad addresses for the iteration.
REQ-016 o_psum_first  output  1  zero-initialise the psum.
REQ-017 o_psum_last  output  1  psum complete.
REQ-018 o_done  output  1  one-cycle pulse on the final iteration.
REQ-019 o_busy  output  1  state is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, INIT, WORK, STALL and DONE.
REQ-021 Transitions: IDLE->INIT on i_start; INIT->WORK after 1 cycle; WORK->STALL on i_stall; STALL->WORK on !i_stall; WORK->DONE on the final fire; DONE->IDLE after 1 cycle.
REQ-022 i_clear SHALL force IDLE from any state, clear all indices and accumulators, and take priority over every other event in the same cycle.
REQ-023 In INIT the block SHALL latch i_size and all strides, and zero all indices and address accumulators; configuration changes after INIT SHALL be ignored.
REQ-024 fire = (state==WORK) && Input_rdy && Weight_rdy && !i_stall.
REQ-025 Input_ack and Weight_ack SHALL both equal fire, combinationally; an operand is never acked alone.
REQ-026 On fire, level 0 SHALL increment; each level k wraps to 0 and carries to k+1 when idx[k]==size[k]-1 and every level below it wraps.
REQ-027 Each address accumulator SHALL be updated incrementally: on increment of level k add stride[k], on wrap of level k subtract (size[k]-1)*stride[k]; arithmetic is modulo 2^AW, and no multiplier is used in the iteration path.
REQ-028 o_valid SHALL be registered and asserted in the cycle after each fire, carrying the addresses of the iteration that fired; latency is 1 cycle.
REQ-029 o_psum_first SHALL be registered and equal 1 when the fired iteration has idx[0..NRED-1] all 0.
REQ-030 o_psum_last SHALL be registered and equal 1 when the fired iteration has idx[0..NRED-1] all at size-1.
REQ-031 o_done SHALL be asserted together with o_valid for the iteration where every level is at size-1.
REQ-032 All size-1 levels: every fire wraps that level; size 1 on every level gives a single iteration, with first, last and done all 1.
REQ-033 A stall arriving while rdy is high SHALL block the fire in that cycle.

Reset
REQ-034 During reset: state IDLE; all indices, accumulators and outputs 0; ack outputs 0.

Configuration
REQ-035 With PE_SEQ_ERROR_EN defined, an output port o_error (1 bit) SHALL exist.
REQ-036 o_error SHALL be sticky: it sets when INIT latches any zero size, or on i_start outside IDLE, and clears only on reset or i_clear.
REQ-037 With PE_SEQ_ERROR_EN defined, a zero size SHALL send INIT->DONE with no fire.
REQ-038 Without PE_SEQ_ERROR_EN, neither the port nor the checks SHALL exist, and a zero size is undefined.

Structure
REQ-039 A shared package pe_seq_pkg SHALL hold the state enum, the NDEPTH/IDXW/AW defaults and a packed loop-control struct {reset, start, stall}.
REQ-040 One sub-module, pe_loop_index, SHALL implement a single level's index, wrap and carry, replicated NDEPTH times via generate.

Verification
REQ-041 sizes {2,3,1,1}, istride {1,2,0,0}, rdy held high -> 6 fires; o_iaddr 0,1,2,3,4,5; o_psum_first on fire 1 only; o_psum_last and o_done on fire 6.
REQ-042 same configuration, Weight_rdy low for 3 cycles mid-nest -> no ack during those cycles, address sequence unchanged, total still 6 fires.
REQ-043 i_stall high for 4 cycles in WORK -> STALL state, no fire, indices held; resumes at the next address.
REQ-044 i_clear asserted on fire 3 -> IDLE next cycle, no o_valid, o_busy 0; a following i_start restarts from address 0.
REQ-045 all sizes 1 -> exactly one o_valid with o_psum_first, o_psum_last and o_done all 1.
REQ-046 with PE_SEQ_ERROR_EN, size[1]=0 -> o_error 1, no fire, o_done pulse, o_error held until i_clear.

Source files
------------

// File: rtl/pe_seq_pkg.sv
// -----------------------------------------------------------------------------
// pe_seq_pkg
// Shared definitions for the PE loop-nest sequencer:
//   - default geometry (loop depth, index width, address width, reduction depth)
//   - pad numbering used to index the per-pad address accumulators
//   - sequencer state encoding
//   - per-level loop control bundle {reset, start, stall}
// Optional feature macro used by the sequencer: PE_SEQ_ERROR_EN.
// -----------------------------------------------------------------------------
package pe_seq_pkg;

    localparam int unsigned NDEPTH_DEF = 32'd4;
    localparam int unsigned IDXW_DEF   = 32'd8;
    localparam int unsigned AW_DEF     = 32'd8;
    localparam int unsigned NRED_DEF   = 32'd2;

    // Three operand pads, each with its own address accumulator.
    localparam int unsigned NPAD  = 32'd3;
    localparam int unsigned PAD_I = 32'd0;
    localparam int unsigned PAD_W = 32'd1;
    localparam int unsigned PAD_P = 32'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_WORK  = 3'd2,
        ST_STALL = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // Control shared by every loop level: reset clears, start loads the
    // level size and zeroes the index, stall freezes the index.
    typedef struct packed {
        logic reset;
        logic start;
        logic stall;
    } loop_ctl_t;

endpackage

// File: rtl/pe_loop_index.sv
// -----------------------------------------------------------------------------
// pe_loop_index
// One level of the loop nest: holds the level's index and latched size,
// increments when the carry from the level below arrives and the nest is not
// stalled, wraps to zero at size-1 and passes the carry upwards.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   reset_i         synchronous clear of index and size
//   start_i         latch size_i and zero the index
//   stall_i         hold the index this cycle
//   size_i          iteration count of this level
//   carry_i         every lower level wraps (tie high for level 0)
//   first_o         index is 0
//   last_o          index is size-1
//   carry_o         this level and every lower level wrap
// -----------------------------------------------------------------------------
module pe_loop_index
    import pe_seq_pkg::*;
#(
    parameter int unsigned IDXW = IDXW_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            stall_i,
    input  logic [IDXW-1:0] size_i,
    input  logic            carry_i,
    output logic            first_o,
    output logic            last_o,
    output logic            carry_o
);

    localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] IDX_ONE  = {{(IDXW-1){1'b0}}, 1'b1};

    logic [IDXW-1:0] idx_q;
    logic [IDXW-1:0] size_q;

    assign first_o = (idx_q == IDX_ZERO);
    assign last_o  = (idx_q == (size_q - IDX_ONE));
    assign carry_o = carry_i & last_o;

    // Index and latched size of this level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= IDX_ZERO;
            size_q <= IDX_ZERO;
        end else if (reset_i) begin
            idx_q  <= IDX_ZERO;
            size_q <= IDX_ZERO;
        end else if (start_i) begin
            idx_q  <= IDX_ZERO;
            size_q <= size_i;
        end else if (!stall_i && carry_i) begin
            idx_q <= last_o ? IDX_ZERO : (idx_q + IDX_ONE);
        end else begin
            idx_q <= idx_q;
        end
    end

endmodule

// File: rtl/pe_loop_sequencer.sv
// -----------------------------------------------------------------------------
// pe_loop_sequencer
// Walks an NDEPTH-deep loop nest (level 0 innermost) and produces, for every
// iteration, the input/weight/psum pad addresses plus psum first/last flags.
// An iteration fires when both operand pads are ready and the nest is running;
// the acks follow the fire combinationally and the addresses of the fired
// iteration appear registered one cycle later.
// Optional feature: define PE_SEQ_ERROR_EN to add the sticky o_error port
// (zero size or start while busy) and a zero-size INIT->DONE escape.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start / i_clear         launch from IDLE / synchronous abort to IDLE
//   i_stall                   freeze iteration
//   i_size                    NDEPTH x IDXW iteration counts (level 0 at LSB)
//   i_istride/i_wstride/i_pstride  NDEPTH x AW per-level strides
//   Input_rdy/Input_ack, Weight_rdy/Weight_ack  operand handshakes
//   o_valid, o_iaddr, o_waddr, o_paddr  registered iteration addresses
//   o_psum_first, o_psum_last           reduction-window boundaries
//   o_done, o_busy                      final-iteration pulse, not-IDLE
//   o_error (PE_SEQ_ERROR_EN only)      sticky configuration/protocol error
// -----------------------------------------------------------------------------
module pe_loop_sequencer
    import pe_seq_pkg::*;
#(
    parameter int unsigned NDEPTH = NDEPTH_DEF,
    parameter int unsigned IDXW   = IDXW_DEF,
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned NRED   = NRED_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_clear,
    input  logic                   i_stall,
    input  logic [NDEPTH*IDXW-1:0] i_size,
    input  logic [NDEPTH*AW-1:0]   i_istride,
    input  logic [NDEPTH*AW-1:0]   i_wstride,
    input  logic [NDEPTH*AW-1:0]   i_pstride,
    input  logic                   Input_rdy,
    output logic                   Input_ack,
    input  logic                   Weight_rdy,
    output logic                   Weight_ack,
    output logic                   o_valid,
    output logic [AW-1:0]          o_iaddr,
    output logic [AW-1:0]          o_waddr,
    output logic [AW-1:0]          o_paddr,
    output logic                   o_psum_first,
    output logic                   o_psum_last,
    output logic                   o_done,
    output logic                   o_busy
`ifdef PE_SEQ_ERROR_EN
    ,
    output logic                   o_error
`endif
);

    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    // Ones on the reduction levels; non-reduction levels are masked out of
    // the psum first/last reductions.
    localparam logic [NDEPTH-1:0] RED_MASK = {NDEPTH{1'b1}} >> (NDEPTH - NRED);

    seq_state_e     state_q;
    loop_ctl_t      ctl_s;
    logic           fire_s;
    logic [NDEPTH:0]   carry_s;
    logic [NDEPTH-1:0] first_s;
    logic [NDEPTH-1:0] last_s;
    logic [NDEPTH-1:0] inc_s;
    logic [NDEPTH-1:0] wrap_s;
    logic           red_first_s;
    logic           red_last_s;

    logic [AW-1:0]  stride_in_s [NPAD][NDEPTH];
    logic [AW-1:0]  stride_q    [NPAD][NDEPTH];
    logic [AW-1:0]  off_q       [NPAD][NDEPTH];
    logic [AW-1:0]  off_d       [NPAD][NDEPTH];
    logic [AW-1:0]  acc_q       [NPAD];
    logic [AW-1:0]  acc_d       [NPAD];
    logic [AW-1:0]  addr_q      [NPAD];

    logic           valid_q;
    logic           first_q;
    logic           last_q;
    logic           done_q;

    assign fire_s     = (state_q == ST_WORK) & Input_rdy & Weight_rdy & ~i_stall;
    assign Input_ack  = fire_s;
    assign Weight_ack = fire_s;

    // Per-level control shared by every index level.
    always_comb begin
        ctl_s.reset = i_clear;
        ctl_s.start = (state_q == ST_INIT);
        ctl_s.stall = ~fire_s;
    end

    // Level 0 always receives the carry; the chain top means "all levels last".
    assign carry_s[0] = 1'b1;

    for (genvar k = 0; k < NDEPTH; k++) begin : g_level
        pe_loop_index #(
            .IDXW (IDXW)
        ) u_idx (
            .clk_i   (i_clk),
            .rst_ni  (i_rst_n),
            .reset_i (ctl_s.reset),
            .start_i (ctl_s.start),
            .stall_i (ctl_s.stall),
            .size_i  (i_size[k*IDXW +: IDXW]),
            .carry_i (carry_s[k]),
            .first_o (first_s[k]),
            .last_o  (last_s[k]),
            .carry_o (carry_s[k+1])
        );
        assign inc_s[k]  = fire_s & carry_s[k];
        assign wrap_s[k] = fire_s & carry_s[k+1];
    end

    assign red_first_s = &(first_s | ~RED_MASK);
    assign red_last_s  = &(last_s  | ~RED_MASK);

    // Unpack the flat stride buses into a [pad][level] view.
    always_comb begin
        for (int k = 0; k < NDEPTH; k++) begin
            stride_in_s[PAD_I][k] = i_istride[k*AW +: AW];
            stride_in_s[PAD_W][k] = i_wstride[k*AW +: AW];
            stride_in_s[PAD_P][k] = i_pstride[k*AW +: AW];
        end
    end

    // Incremental address update. off_q[p][k] tracks idx[k]*stride[k], so on a
    // wrap it is exactly the (size-1)*stride amount to rewind, without a
    // multiplier. Arithmetic wraps modulo 2^AW.
    always_comb begin
        for (int p = 0; p < NPAD; p++) begin
            acc_d[p] = acc_q[p];
            for (int k = 0; k < NDEPTH; k++) begin
                off_d[p][k] = off_q[p][k];
                if (wrap_s[k]) begin
                    acc_d[p]    = acc_d[p] - off_q[p][k];
                    off_d[p][k] = ADDR_ZERO;
                end else if (inc_s[k]) begin
                    acc_d[p]    = acc_d[p] + stride_q[p][k];
                    off_d[p][k] = off_q[p][k] + stride_q[p][k];
                end else begin
                    off_d[p][k] = off_q[p][k];
                end
            end
        end
    end

    // Stride latches, per-level offsets and running pad addresses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int p = 0; p < NPAD; p++) begin
                acc_q[p] <= ADDR_ZERO;
                for (int k = 0; k < NDEPTH; k++) begin
                    off_q[p][k]    <= ADDR_ZERO;
                    stride_q[p][k] <= ADDR_ZERO;
                end
            end
        end else if (i_clear) begin
            for (int p = 0; p < NPAD; p++) begin
                acc_q[p] <= ADDR_ZERO;
                for (int k = 0; k < NDEPTH; k++) begin
                    off_q[p][k]    <= ADDR_ZERO;
                    stride_q[p][k] <= ADDR_ZERO;
                end
            end
        end else if (state_q == ST_INIT) begin
            for (int p = 0; p < NPAD; p++) begin
                acc_q[p] <= ADDR_ZERO;
                for (int k = 0; k < NDEPTH; k++) begin
                    off_q[p][k]    <= ADDR_ZERO;
                    stride_q[p][k] <= stride_in_s[p][k];
                end
            end
        end else if (fire_s) begin
            acc_q <= acc_d;
            off_q <= off_d;
        end else begin
            acc_q <= acc_q;
            off_q <= off_q;
        end
    end

`ifdef PE_SEQ_ERROR_EN
    logic zero_size_s;
    logic err_q;

    // Any level configured with a zero iteration count.
    always_comb begin
        zero_size_s = 1'b0;
        for (int k = 0; k < NDEPTH; k++) begin
            if (i_size[k*IDXW +: IDXW] == {IDXW{1'b0}}) begin
                zero_size_s = 1'b1;
            end else begin
                zero_size_s = zero_size_s;
            end
        end
    end

    // Sticky error flag, cleared only by reset or i_clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (i_clear) begin
            err_q <= 1'b0;
        end else if (((state_q == ST_INIT) && zero_size_s) ||
                     (i_start && (state_q != ST_IDLE))) begin
            err_q <= 1'b1;
        end else begin
            err_q <= err_q;
        end
    end

    assign o_error = err_q;
`endif

    // Sequencer FSM with its registered iteration outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int p = 0; p < NPAD; p++) begin
                addr_q[p] <= ADDR_ZERO;
            end
        end else if (i_clear) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int p = 0; p < NPAD; p++) begin
                addr_q[p] <= ADDR_ZERO;
            end
        end else begin
            valid_q <= fire_s;
            first_q <= fire_s & red_first_s;
            last_q  <= fire_s & red_last_s;
            // carry_s[NDEPTH] means every level is at size-1: final iteration.
            done_q  <= fire_s & carry_s[NDEPTH];
            if (fire_s) begin
                addr_q <= acc_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q <= ST_INIT;
                    end
                end
                ST_INIT: begin
`ifdef PE_SEQ_ERROR_EN
                    if (zero_size_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_WORK;
                    end
`else
                    state_q <= ST_WORK;
`endif
                end
                ST_WORK: begin
                    if (fire_s && carry_s[NDEPTH]) begin
                        state_q <= ST_DONE;
                    end else if (i_stall) begin
                        state_q <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (!i_stall) begin
                        state_q <= ST_WORK;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_valid      = valid_q;
    assign o_iaddr      = addr_q[PAD_I];
    assign o_waddr      = addr_q[PAD_W];
    assign o_paddr      = addr_q[PAD_P];
    assign o_psum_first = first_q;
    assign o_psum_last  = last_q;
    assign o_done       = done_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule
